// File: rtl/div_sqrt_sig_iter_pkg.sv
// Shared types and width helpers for the iterative significand divide/sqrt engine.
package div_sqrt_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  function automatic int unsigned q_w(input int unsigned sig_w);
    return sig_w + 2;
  endfunction

  function automatic int unsigned ncyc(input int unsigned sig_w, input int unsigned iters);
    return (q_w(sig_w) + iters - 1) / iters;
  endfunction

endpackage

// File: rtl/div_sqrt_sig_iter_if.sv
// Request/result bundle between FP unpack, the div/sqrt engine and the rounding stage.
interface div_sqrt_sig_iter_if #(
  parameter int unsigned SIG_W = 53,
  parameter int unsigned TAG_W = 5
);
  logic             in_ready_div;
  logic             in_ready_sqrt;
  logic             in_valid;
  logic             in_sqrt;
  logic [SIG_W-1:0] in_a;
  logic [SIG_W-1:0] in_b;
  logic             in_odd_exp;
  logic [TAG_W-1:0] in_tag;
  logic             kill;
  logic             out_valid_div;
  logic             out_valid_sqrt;
  logic             out_ready;
  logic [SIG_W+1:0] out_q;
  logic             out_sticky;
  logic [TAG_W-1:0] out_tag;

  modport master (
    input  in_ready_div, in_ready_sqrt, out_valid_div, out_valid_sqrt, out_q, out_sticky,
           out_tag,
    output in_valid, in_sqrt, in_a, in_b, in_odd_exp, in_tag, kill, out_ready
  );

  modport slave (
    input  in_valid, in_sqrt, in_a, in_b, in_odd_exp, in_tag, kill, out_ready,
    output in_ready_div, in_ready_sqrt, out_valid_div, out_valid_sqrt, out_q, out_sticky,
           out_tag
  );
endinterface

// File: rtl/div_sqrt_sig_iter_step.sv
// One combinational restoring step: divide (R vs b) or square root (R:2 bits vs 4q+1).
module div_sqrt_sig_step #(
  parameter int unsigned SIG_W = 53
) (
  input  logic             en_i,
  input  logic             sqrt_i,
  input  logic [SIG_W-1:0] b_i,
  input  logic [1:0]       rad_i,
  input  logic [SIG_W+2:0] rem_i,
  input  logic [SIG_W+1:0] q_i,
  output logic [SIG_W+2:0] rem_o,
  output logic [SIG_W+1:0] q_o
);

  logic [SIG_W+4:0] num, den, dif;
  logic             q_bit;
  logic [1:0]       unused_dif;

  always_comb begin
    if (sqrt_i) begin
      num = {rem_i, rad_i};
      den = {1'b0, q_i, 2'b01};
    end else begin
      num = {2'b00, rem_i};
      den = {5'b00000, b_i};
    end
    q_bit = (num >= den);
    dif   = q_bit ? (num - den) : num;
    rem_o = rem_i;
    q_o   = q_i;
    // Disabled steps pass through so surplus iterations of the last cycle are no-ops.
    if (en_i) begin
      q_o   = {q_i[SIG_W:0], q_bit};
      rem_o = sqrt_i ? dif[SIG_W+2:0] : {dif[SIG_W+1:0], 1'b0};
    end
  end

  assign unused_dif = dif[SIG_W+4:SIG_W+3];

endmodule

// File: rtl/div_sqrt_sig_iter.sv
// Iterative significand divide / square-root engine with backpressure, kill and tag passthrough.
module div_sqrt_sig_iter
  import div_sqrt_pkg::*;
#(
  parameter int unsigned SIG_W   = 53,
  parameter int unsigned ITERS   = 1,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned SQRT_EN = 1
) (
  input logic                clk_i,
  input logic                rst_ni,
  div_sqrt_sig_iter_if.slave io
);

  localparam int unsigned QW   = q_w(SIG_W);
  localparam int unsigned NCYC = ncyc(SIG_W, ITERS);
  localparam int unsigned RW   = SIG_W + 3;
  localparam int unsigned XW   = 2 * QW;
  localparam int unsigned CW   = $clog2(NCYC + 1);
  localparam int unsigned LAST = QW - (NCYC - 1) * ITERS;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [QW-1:0]    q_q, q_d;
  logic [XW-1:0]    rad_q, rad_d;
  logic [SIG_W-1:0] b_q, b_d;
  logic             sqrt_q, sqrt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             vdiv_q, vdiv_d, vsqrt_q, vsqrt_d, st_q, st_d;
  logic [QW-1:0]    oq_q, oq_d;
  logic [TAG_W-1:0] otag_q, otag_d;

  logic             rdy_div, rdy_sqrt, accept;
  logic [SIG_W:0]   x_in;
  logic [ITERS-1:0] step_en;
  logic [RW-1:0]    rem_c [ITERS+1];
  logic [QW-1:0]    q_c   [ITERS+1];

  assign rdy_div  = (state_q == StIdle);
  assign rdy_sqrt = (state_q == StIdle) && (SQRT_EN != 0);
  assign x_in     = io.in_odd_exp ? {io.in_a, 1'b0} : {1'b0, io.in_a};

  assign rem_c[0] = rem_q;
  assign q_c[0]   = q_q;

  for (genvar k = 0; k < ITERS; k++) begin : g_step
    assign step_en[k] = (cnt_q != CW'(1)) || (k < LAST);
    div_sqrt_sig_step #(.SIG_W(SIG_W)) u_step (
      .en_i  (step_en[k]),
      .sqrt_i(sqrt_q),
      .b_i   (b_q),
      .rad_i (rad_q[XW-1-2*k -: 2]),
      .rem_i (rem_c[k]),
      .q_i   (q_c[k]),
      .rem_o (rem_c[k+1]),
      .q_o   (q_c[k+1])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    q_d     = q_q;
    rad_d   = rad_q;
    b_d     = b_q;
    sqrt_d  = sqrt_q;
    tag_d   = tag_q;
    vdiv_d  = vdiv_q;
    vsqrt_d = vsqrt_q;
    oq_d    = oq_q;
    st_d    = st_q;
    otag_d  = otag_q;
    accept  = io.in_valid && !io.kill && (io.in_sqrt ? rdy_sqrt : rdy_div);
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StBusy;
          cnt_d   = CW'(NCYC);
          sqrt_d  = io.in_sqrt;
          b_d     = io.in_b;
          tag_d   = io.in_tag;
          q_d     = '0;
          rem_d   = io.in_sqrt ? '0 : {2'b00, io.in_a};
          rad_d   = {x_in, {(SIG_W + 3){1'b0}}};
        end
      end
      StBusy: begin
        // Extra cycle at count 0 registers the result, giving NCYC+1 latency.
        if (cnt_q != '0) begin
          rem_d = rem_c[ITERS];
          q_d   = q_c[ITERS];
          rad_d = rad_q << (2 * ITERS);
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = StDone;
          vdiv_d  = !sqrt_q;
          vsqrt_d = sqrt_q;
          oq_d    = q_q;
          st_d    = |rem_q;
          otag_d  = tag_q;
        end
      end
      StDone: begin
        if (io.out_ready) begin
          state_d = StIdle;
          vdiv_d  = 1'b0;
          vsqrt_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (io.kill) begin
      state_d = StIdle;
      vdiv_d  = 1'b0;
      vsqrt_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      rad_q   <= '0;
      b_q     <= '0;
      sqrt_q  <= 1'b0;
      tag_q   <= '0;
      vdiv_q  <= 1'b0;
      vsqrt_q <= 1'b0;
      oq_q    <= '0;
      st_q    <= 1'b0;
      otag_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      rad_q   <= rad_d;
      b_q     <= b_d;
      sqrt_q  <= sqrt_d;
      tag_q   <= tag_d;
      vdiv_q  <= vdiv_d;
      vsqrt_q <= vsqrt_d;
      oq_q    <= oq_d;
      st_q    <= st_d;
      otag_q  <= otag_d;
    end
  end

  assign io.in_ready_div   = rdy_div;
  assign io.in_ready_sqrt  = rdy_sqrt;
  assign io.out_valid_div  = vdiv_q;
  assign io.out_valid_sqrt = vsqrt_q;
  assign io.out_q          = oq_q;
  assign io.out_sticky     = st_q;
  assign io.out_tag        = otag_q;

endmodule

// File: tb/tb_div_sqrt_sig_iter.sv
// Directed and reference-model bench for div_sqrt_sig_iter across several parameter sets.
module tb_div_sqrt_sig_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [4:0]  t_valid = '0, t_kill = '0, t_ready = '0;
  logic        t_sqrt = 1'b0, t_odd = 1'b0;
  logic [63:0] t_a = '0, t_b = '0;
  logic [4:0]  t_tag = '0;

  logic [4:0]  o_vd, o_vs, o_rd, o_rs, o_st;
  logic [63:0] o_q   [5];
  logic [4:0]  o_tag [5];

  // Instances: 0 = 8/1/sqrt, 1 = 8/2/sqrt, 2 = 8/1/no-sqrt, 3 = 24/1/sqrt, 4 = 53/2/sqrt
  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int unsigned SW = (g < 3) ? 8 : ((g == 3) ? 24 : 53);
    localparam int unsigned IT = (g == 1 || g == 4) ? 2 : 1;
    localparam int unsigned SE = (g == 2) ? 0 : 1;
    div_sqrt_sig_iter_if #(.SIG_W(SW), .TAG_W(5)) bus ();
    div_sqrt_sig_iter #(.SIG_W(SW), .ITERS(IT), .TAG_W(5), .SQRT_EN(SE)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .io    (bus)
    );
    assign bus.in_valid   = t_valid[g];
    assign bus.in_sqrt    = t_sqrt;
    assign bus.in_a       = t_a[SW-1:0];
    assign bus.in_b       = t_b[SW-1:0];
    assign bus.in_odd_exp = t_odd;
    assign bus.in_tag     = t_tag;
    assign bus.kill       = t_kill[g];
    assign bus.out_ready  = t_ready[g];
    assign o_vd[g]        = bus.out_valid_div;
    assign o_vs[g]        = bus.out_valid_sqrt;
    assign o_rd[g]        = bus.in_ready_div;
    assign o_rs[g]        = bus.in_ready_sqrt;
    assign o_st[g]        = bus.out_sticky;
    assign o_q[g]         = 64'(bus.out_q);
    assign o_tag[g]       = bus.out_tag;
  end

  task automatic check_eq(input string tg, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tg, got, exp);
    end
  endtask

  task automatic start_op(input int sel, input logic sq, input logic odd,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
    @(negedge clk);
    t_sqrt = sq; t_odd = odd; t_a = a; t_b = b; t_tag = tag;
    t_valid[sel] = 1'b1;
    @(posedge clk);
    #1 t_valid[sel] = 1'b0;
  endtask

  task automatic wait_valid(input int sel, input int lat, input string nm);
    int n = 1;
    while (!(o_vd[sel] | o_vs[sel]) && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    check_eq({nm, "_lat"}, 64'(n - 1), 64'(lat));
  endtask

  task automatic finish_op(input int sel, input logic sq, input logic [63:0] eq, input logic es,
                           input logic [4:0] etag, input string nm);
    check_eq({nm, "_q"}, o_q[sel], eq);
    check_eq({nm, "_sticky"}, 64'(o_st[sel]), 64'(es));
    check_eq({nm, "_tag"}, 64'(o_tag[sel]), 64'(etag));
    check_eq({nm, "_vdiv"}, 64'(o_vd[sel]), 64'(!sq));
    check_eq({nm, "_vsqrt"}, 64'(o_vs[sel]), 64'(sq));
    t_ready[sel] = 1'b1;
    @(posedge clk);
    #1 t_ready[sel] = 1'b0;
    check_eq({nm, "_idle"}, 64'({o_rd[sel], o_vd[sel], o_vs[sel]}), 64'(3'b100));
  endtask

  task automatic run_op(input int sel, input logic sq, input logic odd, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] tag, input int lat,
                        input logic [63:0] eq, input logic es, input string nm);
    start_op(sel, sq, odd, a, b, tag);
    wait_valid(sel, lat, nm);
    finish_op(sel, sq, eq, es, tag, nm);
  endtask

  task automatic expect_quiet(input int sel, input int cycles, input string nm);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1 seen = seen | o_vd[sel] | o_vs[sel];
    end
    check_eq({nm, "_novalid"}, 64'(seen), 64'(0));
  endtask

  function automatic logic [63:0] isqrt(input logic [127:0] x);
    logic [63:0] r = '0;
    for (int i = 57; i >= 0; i--) begin
      logic [63:0] c = r | (64'd1 << i);
      if (128'(c) * 128'(c) <= x) r = c;
    end
    return r;
  endfunction

  int sels [3] = '{0, 3, 4};
  int sws  [3] = '{8, 24, 53};
  int lats [3] = '{11, 27, 29};

  initial begin
    logic [63:0] a, b, eq, x;
    logic [127:0] num, xx;
    logic es, sq, odd;
    logic [4:0] tg;
    int sw;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out", {o_q[0][59:0], o_st[0], o_vd[0], o_vs[0], 1'b0}, 64'(0));
    check_eq("rst_tag", 64'(o_tag[0]), 64'(0));
    check_eq("rst_rdy", 64'({o_rd[0], o_rs[0], o_rs[2]}), 64'(3'b110));
    @(negedge clk) rst_n = 1'b1;

    run_op(0, 0, 0, 64'h80, 64'h80, 5'h01, 11, 64'h200, 0, "div_1");
    run_op(0, 0, 0, 64'h80, 64'hC0, 5'h13, 11, 64'h155, 1, "div_2");
    run_op(0, 1, 0, 64'h80, 64'h00, 5'h05, 11, 64'h200, 0, "sqrt_e");
    run_op(0, 1, 1, 64'h80, 64'h00, 5'h1F, 11, 64'h2D4, 1, "sqrt_o");
    run_op(0, 0, 0, 64'hFF, 64'h80, 5'h02, 11, 64'h3FC, 0, "div_max");
    run_op(1, 0, 0, 64'h80, 64'h80, 5'h01, 6, 64'h200, 0, "i2_div_1");
    run_op(1, 0, 0, 64'h80, 64'hC0, 5'h13, 6, 64'h155, 1, "i2_div_2");
    run_op(1, 1, 0, 64'h80, 64'h00, 5'h05, 6, 64'h200, 0, "i2_sqrt_e");
    run_op(1, 1, 1, 64'h80, 64'h00, 5'h0A, 6, 64'h2D4, 1, "i2_sqrt_o");

    // Backpressure: result must hold while out_ready stays low.
    start_op(0, 0, 0, 64'h80, 64'hC0, 5'h13);
    wait_valid(0, 11, "bp");
    repeat (20) @(posedge clk);
    #1;
    check_eq("bp_hold", {o_q[0][59:0], o_st[0], o_vd[0], o_vs[0], 1'b0},
             {60'h155, 1'b1, 1'b1, 1'b0, 1'b0});
    check_eq("bp_rdy_low", 64'({o_rd[0], o_rs[0]}), 64'(0));
    finish_op(0, 0, 64'h155, 1, 5'h13, "bp");

    // Kill mid-busy.
    start_op(0, 0, 0, 64'h80, 64'hC0, 5'h04);
    repeat (4) @(posedge clk);
    @(negedge clk) t_kill[0] = 1'b1;
    @(posedge clk);
    #1 t_kill[0] = 1'b0;
    check_eq("kill_busy_idle", 64'(o_rd[0]), 64'(1));
    expect_quiet(0, 14, "kill_busy");
    // Kill beats a same-cycle accept.
    @(negedge clk);
    t_sqrt = 1'b0; t_a = 64'h80; t_b = 64'h80; t_valid[0] = 1'b1; t_kill[0] = 1'b1;
    @(posedge clk);
    #1 begin t_valid[0] = 1'b0; t_kill[0] = 1'b0; end
    check_eq("kill_acc_idle", 64'(o_rd[0]), 64'(1));
    expect_quiet(0, 14, "kill_acc");
    // Kill beats a same-cycle output handshake.
    start_op(0, 0, 0, 64'h80, 64'hC0, 5'h06);
    wait_valid(0, 11, "kill_done");
    @(negedge clk) begin t_kill[0] = 1'b1; t_ready[0] = 1'b1; end
    @(posedge clk);
    #1 begin t_kill[0] = 1'b0; t_ready[0] = 1'b0; end
    check_eq("kill_done_idle", 64'({o_rd[0], o_vd[0]}), 64'(2'b10));
    run_op(0, 1, 1, 64'h80, 64'h00, 5'h07, 11, 64'h2D4, 1, "after_kill");

    // Asynchronous reset mid-busy.
    start_op(0, 0, 0, 64'h80, 64'hC0, 5'h08);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check_eq("arst_state", {o_q[0][61:0], o_rd[0], o_vd[0]}, {62'h0, 1'b1, 1'b0});
    @(negedge clk) rst_n = 1'b1;
    expect_quiet(0, 14, "arst");
    run_op(0, 0, 0, 64'h80, 64'hC0, 5'h09, 11, 64'h155, 1, "after_arst");

    // SQRT_EN=0: sqrt request ignored, divides still work.
    start_op(2, 1, 0, 64'h80, 64'h00, 5'h0B);
    check_eq("nosqrt_idle", 64'({o_rd[2], o_rs[2]}), 64'(2'b10));
    expect_quiet(2, 14, "nosqrt");
    run_op(2, 0, 0, 64'h80, 64'hC0, 5'h0C, 11, 64'h155, 1, "nosqrt_div");

    // Illegal divisor (MSB clear): result unspecified, completion time is not.
    start_op(0, 0, 0, 64'hFF, 64'h01, 5'h0D);
    wait_valid(0, 11, "illegal");
    @(negedge clk) t_ready[0] = 1'b1;
    @(posedge clk);
    #1 t_ready[0] = 1'b0;
    check_eq("illegal_idle", 64'(o_rd[0]), 64'(1));

    // Reference-model sweep.
    for (int s = 0; s < 3; s++) begin
      sw = sws[s];
      for (int i = 0; i < 8; i++) begin
        sq  = i[0];
        odd = i[1];
        a   = ({$urandom, $urandom} & ((64'd1 << (sw - 1)) - 1)) | (64'd1 << (sw - 1));
        b   = ({$urandom, $urandom} & ((64'd1 << (sw - 1)) - 1)) | (64'd1 << (sw - 1));
        tg  = 5'($urandom);
        if (!sq) begin
          num = 128'(a) << (sw + 1);
          eq  = 64'(num / 128'(b));
          es  = (num % 128'(b)) != 0;
        end else begin
          x  = odd ? (a << 1) : a;
          xx = 128'(x) << (sw + 3);
          eq = isqrt(xx);
          es = (128'(eq) * 128'(eq)) != xx;
        end
        run_op(sels[s], sq, odd, a, b, tg, lats[s], eq, es, $sformatf("rnd_w%0d_%0d", sw, i));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
